// File: rtl/c32b_8b_arb_if.sv
// Bus bundle for c32b_8b_arb: four 32-bit word requesters on one side,
// the serialized byte stream plus grant status on the other.
// master: requester/consumer side; slave: the arbiter itself.
interface c32b_8b_arb_if;
  logic [3:0]  req_valid;
  logic [31:0] data_in0;
  logic [31:0] data_in1;
  logic [31:0] data_in2;
  logic [31:0] data_in3;
  logic [3:0]  req_ready;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        sof;
  logic [1:0]  grant_id;
  logic        busy;

  modport master (
    output req_valid, data_in0, data_in1, data_in2, data_in3,
    input  req_ready, data_out, valid_out, sof, grant_id, busy
  );

  modport slave (
    input  req_valid, data_in0, data_in1, data_in2, data_in3,
    output req_ready, data_out, valid_out, sof, grant_id, busy
  );
endinterface

// File: rtl/c32b_8b_arb.sv
// c32b_8b_arb: arbitrates four 32-bit word sources onto one byte lane,
// emitting each granted word as four bytes, LSB first, back-to-back.
// Build option: define C32B8_ARB_STRICT_PRIO_EN for fixed priority
// (requester 0 highest); default is round-robin.
module c32b_8b_arb #(
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input logic           clock,
  input logic           reset,
  c32b_8b_arb_if.slave  bus
);

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  state_e      state_q;
  logic [1:0]  phase_q;
  logic [31:8] hold_q;     // byte 0 leaves directly from the input mux
  logic [7:0]  data_q;
  logic        sof_q;
  logic [1:0]  grant_q;
`ifndef C32B8_ARB_STRICT_PRIO_EN
  logic [1:0]  rr_last_q;
  logic [1:0]  idx;
`endif

  logic        can_accept;
  logic        found;
  logic        accept;
  logic [1:0]  win;
  logic [31:0] win_data;
  logic [1:0]  phase_d;

  assign can_accept = (state_q == ST_IDLE) || (phase_q == 2'd3);
  assign accept     = can_accept && found && !reset;
  assign phase_d    = phase_q + 2'd1;

  // Winner search: first valid requester in priority order
  always_comb begin
    win   = '0;
    found = 1'b0;
`ifdef C32B8_ARB_STRICT_PRIO_EN
    for (int unsigned k = 0; k < 4; k++) begin
      if (!found && bus.req_valid[k]) begin
        found = 1'b1;
        win   = 2'(k);
      end
    end
`else
    idx = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = rr_last_q + 2'(k);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
`endif
  end

  // Word mux for the winning requester
  always_comb begin
    case (win)
      2'd0:    win_data = bus.data_in0;
      2'd1:    win_data = bus.data_in1;
      2'd2:    win_data = bus.data_in2;
      default: win_data = bus.data_in3;
    endcase
  end

  assign bus.req_ready = accept ? (4'(1) << win) : '0;
  assign bus.data_out  = data_q;
  assign bus.valid_out = (state_q == ST_SEND);
  assign bus.busy      = (state_q == ST_SEND);
  assign bus.sof       = sof_q;
  assign bus.grant_id  = grant_q;

  // Sequencer: load on accept, then step through bytes 1..3, then idle
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      hold_q    <= '0;
      data_q    <= IDLE_BYTE;
      sof_q     <= 1'b0;
      grant_q   <= '0;
`ifndef C32B8_ARB_STRICT_PRIO_EN
      rr_last_q <= 2'd3;
`endif
    end else if (accept) begin
      state_q   <= ST_SEND;
      phase_q   <= '0;
      hold_q    <= win_data[31:8];
      data_q    <= win_data[7:0];
      sof_q     <= 1'b1;
      grant_q   <= win;
`ifndef C32B8_ARB_STRICT_PRIO_EN
      rr_last_q <= win;
`endif
    end else if (state_q == ST_SEND) begin
      if (phase_q != 2'd3) begin
        phase_q <= phase_d;
        sof_q   <= 1'b0;
        case (phase_d)
          2'd1:    data_q <= hold_q[15:8];
          2'd2:    data_q <= hold_q[23:16];
          default: data_q <= hold_q[31:24];
        endcase
      end else begin
        state_q <= ST_IDLE;
        data_q  <= IDLE_BYTE;
        sof_q   <= 1'b0;
      end
    end
  end

endmodule
